// File: rtl/key_clock_gen.sv
// Divided serial clock generator (burst of N cycles or continuous while enabled)
// with registered iClock-domain rise/fall strobes, busy level and done pulse.
module key_clock_gen #(
  parameter int HALF_PERIOD = 4001,
  parameter int CNT_W       = 12,
  parameter int NB_W        = 4
) (
  input  logic            iClock,
  input  logic            iReset_n,
  input  logic            iEnable,
  input  logic            iStart,
  input  logic [NB_W-1:0] iCount,
  output logic            oClock,
  output logic            oFall,
  output logic            oRise,
  output logic            oBusy,
  output logic            oDone
);

  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_PERIOD - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NB_W-1:0]   rem_q, rem_d;
  logic              burst_q, burst_d;
  logic              clk_q, clk_d;
  logic              fall_q, fall_d;
  logic              rise_q, rise_d;
  logic              done_q, done_d;
  logic              phase_end;
  logic              go_low;

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      burst_q <= 1'b0;
      clk_q   <= 1'b1;
      fall_q  <= 1'b0;
      rise_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      burst_q <= burst_d;
      clk_q   <= clk_d;
      fall_q  <= fall_d;
      rise_q  <= rise_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    burst_d   = burst_q;
    clk_d     = clk_q;
    fall_d    = 1'b0;
    rise_d    = 1'b0;
    done_d    = 1'b0;
    go_low    = 1'b0;
    phase_end = (cnt_q == CNT_LAST);

    case (state_q)
      S_IDLE: begin
        clk_d = 1'b1;
        cnt_d = '0;
        if (iStart) begin
          if (iCount != '0) begin
            rem_d   = iCount;
            burst_d = 1'b1;
            go_low  = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end else if (iEnable) begin
          burst_d = 1'b0;
          go_low  = 1'b1;
        end
      end
      S_LOW: begin
        if (phase_end) begin
          cnt_d   = '0;
          state_d = S_HIGH;
          clk_d   = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HIGH: begin
        if (phase_end) begin
          cnt_d = '0;
          if (burst_q) begin
            // remaining saturates at zero; the run continues only if cycles are left
            if (rem_q != '0) rem_d = rem_q - 1'b1;
            go_low = (rem_q > NB_W'(1));
          end else begin
            go_low = iEnable;
          end
          if (!go_low) begin
            state_d = S_IDLE;
            clk_d   = 1'b1;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        clk_d   = 1'b1;
      end
    endcase

    if (go_low) begin
      state_d = S_LOW;
      cnt_d   = '0;
      clk_d   = 1'b0;
      fall_d  = 1'b1;
    end
  end

  assign oClock = clk_q;
  assign oFall  = fall_q;
  assign oRise  = rise_q;
  assign oBusy  = (state_q != S_IDLE);
  assign oDone  = done_q;

endmodule

// File: doc/key_clock_gen.md
Name: key_clock_gen

Overview:
Parametrised serial-clock generator for keyboard/serial-bus interfaces. It derives a slow, glitch-free oClock from iClock by dividing the system clock. It runs in two modes: a burst mode that emits exactly N clock cycles per start request, and a continuous mode that runs while iEnable is held. It also provides single-cycle rise/fall strobes in the iClock domain, so the adjacent shift registers sample and drive data without using oClock as a clock.

Parameters:
HALF_PERIOD, 4001, iClock cycles per oClock half-period; legal range 1 .. 2^CNT_W-1.
CNT_W, 12, width of the half-period counter.
NB_W, 4, width of the burst-count input and remaining-cycle counter.

Ports:
iClock  in  1  system clock; all logic on rising edge.
iReset_n  in  1  reset, asynchronous assert, active-low.
iEnable  in  1  continuous-mode request; level-sensitive.
iStart  in  1  burst request; sampled only in IDLE.
iCount  in  NB_W  number of oClock cycles in the burst; latched with iStart.
oClock  out  1  generated serial clock; idles high.
oFall  out  1  one-cycle strobe, high in the first cycle oClock is 0.
oRise  out  1  one-cycle strobe, high in the first cycle oClock is 1 after a low phase.
oBusy  out  1  high while in LOW or HIGH state.
oDone  out  1  one-cycle pulse when the generator returns to IDLE.

Behaviour:
- Reset (iReset_n=0, asynchronous):
  - state=IDLE; oClock=1; oFall=oRise=oBusy=oDone=0.
  - Half-period counter=0; remaining counter=0; mode flag=0.
  - Reset mid-burst aborts immediately. No oDone is issued.
- States: IDLE, LOW, HIGH. All outputs are registered.
- IDLE:
  - oClock=1.
  - If iStart=1 and iCount!=0: latch remaining=iCount, set mode=burst, go to LOW.
  - Else if iStart=1 and iCount==0: stay in IDLE and pulse oDone next cycle. No clock activity.
  - Else if iEnable=1: set mode=continuous, go to LOW.
  - iStart has priority over iEnable when both are high.
- Entry to LOW (cycle after the request is sampled): oClock=0 and oFall=1 for that one cycle.
- Phase length: oClock stays at each level for exactly HALF_PERIOD iClock cycles.
  - The counter runs 0..HALF_PERIOD-1 and clears on every phase change.
- LOW -> HIGH after HALF_PERIOD cycles; oClock=1 and oRise=1 in the first HIGH cycle.
- End of HIGH phase (after HALF_PERIOD cycles):
  - Burst mode: decrement remaining. If the result is 0, go to IDLE. Otherwise go to LOW with an oFall strobe.
  - Continuous mode: if iEnable=1 (sampled in the last HIGH cycle), go to LOW. Otherwise go to IDLE.
- oDone=1 for exactly the first IDLE cycle after any completed burst or continuous run.
- Timing example (request sampled at cycle t, HP=HALF_PERIOD):
  - oClock low in cycles t+1 .. t+HP.
  - oClock high in cycles t+HP+1 .. t+2HP.
  - If that is the last cycle: IDLE and oDone=1 at cycle t+2HP+1.
  - Total burst duration = 2*HP*N cycles.
- Glitch-free: a run always ends after a complete high phase. oClock never changes outside the phase boundaries above.
- Requests are ignored while oBusy=1:
  - iStart is not queued.
  - iCount changes have no effect once latched.
  - iEnable only matters in continuous mode at the end of a HIGH phase.
- A back-to-back request in the oDone cycle is accepted normally; the new LOW phase starts the following cycle.
- Counters never wrap: the half-period counter clears at HP-1, and remaining stops at 0.

Test Plan:
1. Reset, HALF_PERIOD=3, iStart pulse with iCount=2 at cycle 10 -> oClock low cycles 11-13, high 14-16, low 17-19, high 20-22. oFall at 11 and 17, oRise at 14 and 20. oDone at 23. oBusy high cycles 11-22.
2. iStart with iCount=0 -> oClock stays 1, oBusy stays 0, oDone=1 exactly one cycle later.
3. HALF_PERIOD=3, iEnable high for 8 cycles starting at cycle 10, then low -> two full oClock cycles (the second completes despite iEnable dropping mid-low). oDone at cycle 23. No truncated pulse.
4. iStart and iEnable both high in IDLE with iCount=1 -> exactly one oClock cycle, then IDLE. iEnable still high then starts a new continuous run after the oDone cycle.
5. iReset_n driven low mid-LOW phase of a burst -> oClock=1 and oBusy=0 immediately (asynchronous). No oDone. A new iStart after release runs the full iCount.
6. HALF_PERIOD=1 with iCount=15 (max for NB_W=4) -> oClock toggles every cycle for 30 cycles, with exactly 15 oRise and 15 oFall strobes and one oDone.
